// File: rtl/co2_alarm_ctrl_if.sv
// Detector-side signal bundle for co2_alarm_ctrl. The master drives the
// detection flag and the operator acknowledge. The slave returns the alarm status.
interface co2_alarm_ctrl_if #(
    parameter int CW = 4
);
    logic          Z;
    logic          ACK;
    logic          ALARM;
    logic          WARN;
    logic [CW-1:0] DET_CNT;

    modport master (
        output Z,
        output ACK,
        input  ALARM,
        input  WARN,
        input  DET_CNT
    );

    modport slave (
        input  Z,
        input  ACK,
        output ALARM,
        output WARN,
        output DET_CNT
    );
endinterface

// File: rtl/co2_alarm_ctrl.sv
// CO2 alarm controller: counts rising edges of Z inside a window and raises a held, retriggerable ALARM.
// Optional feature: define CO2_ALARM_LATCH_EN to keep ALARM latched until acknowledged.
module co2_alarm_ctrl #(
    parameter int THRESH = 3,
    parameter int WINDOW = 1000,
    parameter int HOLD   = 500,
    parameter int CW     = 4
) (
    input  logic            CLK,
    input  logic            RST,
    co2_alarm_ctrl_if.slave bus
);

    localparam int WTW = $clog2(WINDOW);
    localparam int HTW = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [WTW-1:0] WIN_LAST  = WTW'(WINDOW - 1);
    localparam logic [HTW-1:0] HOLD_LAST = HTW'(HOLD - 1);
    localparam logic [CW-1:0]  THRESH_C  = CW'(THRESH);
    localparam logic [CW-1:0]  THRESH_M1 = CW'(THRESH - 1);
    localparam logic [CW-1:0]  CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

`ifdef CO2_ALARM_LATCH_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_ALARM   = 2'd2,
        ST_LATCHED = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_ALARM = 2'd2
    } state_t;
`endif

    state_t         state_r;
    state_t         state_s;
    logic           z_prev_r;
    logic           z_armed_r;
    logic           event_s;
    logic [WTW-1:0] win_timer_r;
    logic [WTW-1:0] win_timer_s;
    logic [HTW-1:0] hold_timer_r;
    logic [HTW-1:0] hold_timer_s;
    logic [CW-1:0]  det_cnt_r;
    logic [CW-1:0]  det_cnt_s;
    logic           alarm_r;
    logic           alarm_s;
    logic           warn_r;
    logic           warn_s;

`ifdef CO2_ALARM_LATCH_EN
    logic           pending_r;
    logic           pending_s;
`else
    logic           unused_ack_s;
    assign unused_ack_s = bus.ACK;
`endif

    // A level of Z present at reset release is not an event until Z has been seen low.
    assign event_s = bus.Z & ~z_prev_r & z_armed_r;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; the threshold check wins over window expiry, and a retrigger wins over hold expiry
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (event_s) begin
                    state_s = ST_COUNT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (event_s && (det_cnt_r == THRESH_M1)) begin
                    state_s = ST_ALARM;
                end else if (!event_s && (win_timer_r == WIN_LAST)) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_COUNT;
                end
            end
            ST_ALARM: begin
                if (event_s) begin
                    state_s = ST_ALARM;
                end else if (hold_timer_r == HOLD_LAST) begin
`ifdef CO2_ALARM_LATCH_EN
                    if (pending_r || bus.ACK) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_LATCHED;
                    end
`else
                    state_s = ST_IDLE;
`endif
                end else begin
                    state_s = ST_ALARM;
                end
            end
`ifdef CO2_ALARM_LATCH_EN
            ST_LATCHED: begin
                if (bus.ACK) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_LATCHED;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Window timer, hold timer and detection count for the next cycle
    always_comb begin
        win_timer_s  = {WTW{1'b0}};
        hold_timer_s = {HTW{1'b0}};
        det_cnt_s    = det_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (event_s) begin
                    det_cnt_s = CNT_ONE;
                end else begin
                    det_cnt_s = CNT_ZERO;
                end
            end
            ST_COUNT: begin
                if (state_s == ST_ALARM) begin
                    det_cnt_s = THRESH_C;
                end else if (state_s == ST_IDLE) begin
                    det_cnt_s = CNT_ZERO;
                end else if (win_timer_r == WIN_LAST) begin
                    // Event on the last window cycle opens a fresh window.
                    det_cnt_s = CNT_ONE;
                end else begin
                    win_timer_s = win_timer_r + WTW'(1);
                    if (event_s) begin
                        det_cnt_s = det_cnt_r + CNT_ONE;
                    end else begin
                        det_cnt_s = det_cnt_r;
                    end
                end
            end
            ST_ALARM: begin
                if (state_s == ST_ALARM) begin
                    det_cnt_s = THRESH_C;
                    if (event_s) begin
                        hold_timer_s = {HTW{1'b0}};
                    end else begin
                        hold_timer_s = hold_timer_r + HTW'(1);
                    end
                end else if (state_s == ST_IDLE) begin
                    det_cnt_s = CNT_ZERO;
                end else begin
                    det_cnt_s = THRESH_C;
                end
            end
`ifdef CO2_ALARM_LATCH_EN
            ST_LATCHED: begin
                if (state_s == ST_IDLE) begin
                    det_cnt_s = CNT_ZERO;
                end else begin
                    det_cnt_s = THRESH_C;
                end
            end
`endif
            default: begin
                det_cnt_s = CNT_ZERO;
            end
        endcase
    end

`ifdef CO2_ALARM_LATCH_EN
    // Acknowledge seen during the alarm hold; cleared whenever the alarm hold ends
    always_comb begin
        if ((state_r == ST_ALARM) && (state_s == ST_ALARM)) begin
            pending_s = pending_r | bus.ACK;
        end else begin
            pending_s = 1'b0;
        end
    end
`endif

    // Output decode from the next state so the registered outputs line up with the state
    always_comb begin
        alarm_s = 1'b0;
        warn_s  = 1'b0;
        case (state_s)
            ST_IDLE: begin
                alarm_s = 1'b0;
                warn_s  = 1'b0;
            end
            ST_COUNT: begin
                warn_s = 1'b1;
            end
            ST_ALARM: begin
                alarm_s = 1'b1;
            end
`ifdef CO2_ALARM_LATCH_EN
            ST_LATCHED: begin
                alarm_s = 1'b1;
            end
`endif
            default: begin
                alarm_s = 1'b0;
                warn_s  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            z_prev_r     <= 1'b0;
            z_armed_r    <= 1'b0;
            win_timer_r  <= {WTW{1'b0}};
            hold_timer_r <= {HTW{1'b0}};
            det_cnt_r    <= CNT_ZERO;
            alarm_r      <= 1'b0;
            warn_r       <= 1'b0;
`ifdef CO2_ALARM_LATCH_EN
            pending_r    <= 1'b0;
`endif
        end else begin
            z_prev_r     <= bus.Z;
            z_armed_r    <= z_armed_r | ~bus.Z;
            win_timer_r  <= win_timer_s;
            hold_timer_r <= hold_timer_s;
            det_cnt_r    <= det_cnt_s;
            alarm_r      <= alarm_s;
            warn_r       <= warn_s;
`ifdef CO2_ALARM_LATCH_EN
            pending_r    <= pending_s;
`endif
        end
    end

    assign bus.ALARM   = alarm_r;
    assign bus.WARN    = warn_r;
    assign bus.DET_CNT = det_cnt_r;

endmodule

// File: tb/tb_co2_alarm_ctrl.sv
// Scoreboard bench for co2_alarm_ctrl: a behavioural model queues expected outputs per cycle,
// plus directed cycle checks for the documented scenarios.
module tb_co2_alarm_ctrl;

    localparam int THRESH = 3;
    localparam int WINDOW = 16;
    localparam int HOLD   = 8;
    localparam int CW     = 4;
`ifdef CO2_ALARM_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    co2_alarm_ctrl_if #(.CW(CW)) bus ();

    co2_alarm_ctrl #(
        .THRESH (THRESH),
        .WINDOW (WINDOW),
        .HOLD   (HOLD),
        .CW     (CW)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct packed {
        logic          alarm;
        logic          warn;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int m_st, m_cnt, m_win, m_hold;
    bit m_pend, m_zprev, m_armed;

    logic          h_alarm [0:64];
    logic          h_warn  [0:64];
    logic [CW-1:0] h_cnt   [0:64];

    logic [63:0] zm, am, rm;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pb(input int a = -1, input int b = -1, input int c = -1,
                                       input int d = -1, input int e = -1, input int f = -1);
        logic [63:0] m;
        m = 64'd0;
        if (a >= 0) m[a] = 1'b1;
        if (b >= 0) m[b] = 1'b1;
        if (c >= 0) m[c] = 1'b1;
        if (d >= 0) m[d] = 1'b1;
        if (e >= 0) m[e] = 1'b1;
        if (f >= 0) m[f] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] span(input int lo, input int hi);
        logic [63:0] m;
        m = 64'd0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Behavioural model: advance one clock edge, then queue the outputs expected after it.
    task automatic model_step(input bit z, input bit ack, input bit rst);
        bit   ev, pn;
        exp_t e;
        if (rst) begin
            m_st = 0; m_cnt = 0; m_win = 0; m_hold = 0;
            m_pend = 1'b0; m_zprev = 1'b0; m_armed = 1'b0;
        end else begin
            ev = z && !m_zprev && m_armed;
            m_armed = m_armed || !z;
            m_zprev = z;
            if (m_st == 0) begin
                if (ev) begin m_st = 1; m_cnt = 1; m_win = 0; end
            end else if (m_st == 1) begin
                if (ev && (m_cnt + 1 == THRESH)) begin
                    m_st = 2; m_cnt = THRESH; m_hold = 0; m_pend = 1'b0;
                end else if (m_win == WINDOW - 1) begin
                    if (ev) begin m_cnt = 1; m_win = 0; end
                    else begin m_st = 0; m_cnt = 0; m_win = 0; end
                end else begin
                    m_win++;
                    if (ev) m_cnt++;
                end
            end else if (m_st == 2) begin
                pn = LATCH && (m_pend || ack);
                if (ev) begin
                    m_hold = 0; m_pend = pn;
                end else if (m_hold == HOLD - 1) begin
                    m_hold = 0; m_pend = 1'b0;
                    if (LATCH && !pn) m_st = 3;
                    else begin m_st = 0; m_cnt = 0; end
                end else begin
                    m_hold++; m_pend = pn;
                end
            end else begin
                if (ack) begin m_st = 0; m_cnt = 0; end
            end
        end
        e.alarm = (m_st >= 2);
        e.warn  = (m_st == 1);
        e.cnt   = CW'(m_cnt);
        sb_q.push_back(e);
    endtask

    task automatic sb_compare(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_underflow"}, 1, 0);
        end else begin
            e = sb_q.pop_front();
            check_val(tag, int'({bus.ALARM, bus.WARN, bus.DET_CNT}), int'(e));
        end
    endtask

    // One-cycle reset, then ncyc cycles; bit c of each mask is the input during cycle c.
    task automatic run(input string nm, input int ncyc, input logic [63:0] z_m,
                       input logic [63:0] a_m, input logic [63:0] r_m, input logic rst_z);
        RST = 1'b1; bus.Z = rst_z; bus.ACK = 1'b0;
        model_step(rst_z, 1'b0, 1'b1);
        @(posedge CLK); #1;
        check_val({nm, "_rst_outs"}, int'({bus.ALARM, bus.WARN, bus.DET_CNT}), 0);
        sb_compare({nm, "_rst"});
        h_alarm[0] = bus.ALARM; h_warn[0] = bus.WARN; h_cnt[0] = bus.DET_CNT;
        for (int c = 0; c < ncyc; c++) begin
            RST = r_m[c]; bus.Z = z_m[c]; bus.ACK = a_m[c];
            model_step(z_m[c], a_m[c], r_m[c]);
            @(posedge CLK); #1;
            sb_compare($sformatf("%s_c%0d", nm, c + 1));
            h_alarm[c+1] = bus.ALARM; h_warn[c+1] = bus.WARN; h_cnt[c+1] = bus.DET_CNT;
        end
        RST = 1'b0; bus.Z = 1'b0; bus.ACK = 1'b0;
    endtask

    initial begin
        bus.Z = 1'b0; bus.ACK = 1'b0;

        // Three pulses raise the alarm for HOLD cycles
        run("basic", 20, pb(2, 5, 8), 64'd0, 64'd0, 1'b0);
        check_val("basic_cnt3", h_cnt[3], 1);
        check_val("basic_cnt6", h_cnt[6], 2);
        check_val("basic_warn3", h_warn[3], 1);
        check_val("basic_warn8", h_warn[8], 1);
        check_val("basic_warn9", h_warn[9], 0);
        check_val("basic_alarm8", h_alarm[8], 0);
        check_val("basic_alarm9", h_alarm[9], 1);
        check_val("basic_alarm16", h_alarm[16], 1);
`ifdef CO2_ALARM_LATCH_EN
        check_val("basic_alarm17", h_alarm[17], 1);
`else
        check_val("basic_alarm17", h_alarm[17], 0);
        check_val("basic_cnt17", h_cnt[17], 0);
`endif

        // Two pulses then window expiry
        run("expire", 22, pb(2, 5), 64'd0, 64'd0, 1'b0);
        check_val("expire_cnt18", h_cnt[18], 2);
        check_val("expire_warn18", h_warn[18], 1);
        check_val("expire_cnt19", h_cnt[19], 0);
        check_val("expire_warn19", h_warn[19], 0);
        check_val("expire_alarm12", h_alarm[12], 0);

        // Held Z counts once
        run("held", 18, span(2, 7) | pb(10, 13), 64'd0, 64'd0, 1'b0);
        check_val("held_cnt8", h_cnt[8], 1);
        check_val("held_cnt11", h_cnt[11], 2);
        check_val("held_alarm11", h_alarm[11], 0);
        check_val("held_alarm14", h_alarm[14], 1);

        // Retrigger during hold
        run("retrig", 26, pb(2, 5, 8, 14), 64'd0, 64'd0, 1'b0);
        check_val("retrig_alarm17", h_alarm[17], 1);
        check_val("retrig_alarm22", h_alarm[22], 1);
        check_val("retrig_cnt20", h_cnt[20], THRESH);
`ifdef CO2_ALARM_LATCH_EN
        check_val("retrig_alarm23", h_alarm[23], 1);
`else
        check_val("retrig_alarm23", h_alarm[23], 0);
`endif

        // Reset during alarm, then fresh pulses
        run("rstalarm", 24, pb(2, 5, 8, 15, 18, 21), 64'd0, pb(12), 1'b0);
        check_val("rstalarm_alarm12", h_alarm[12], 1);
        check_val("rstalarm_outs13", int'({h_alarm[13], h_warn[13], h_cnt[13]}), 0);
        check_val("rstalarm_cnt19", h_cnt[19], 2);
        check_val("rstalarm_alarm21", h_alarm[21], 0);
        check_val("rstalarm_alarm22", h_alarm[22], 1);

        // Z high through reset release is not an event
        run("zrst", 16, span(0, 4) | pb(7, 10, 13), 64'd0, 64'd0, 1'b1);
        check_val("zrst_cnt1", h_cnt[1], 0);
        check_val("zrst_warn5", h_warn[5], 0);
        check_val("zrst_cnt8", h_cnt[8], 1);
        check_val("zrst_alarm14", h_alarm[14], 1);

        // Event on the last window cycle restarts the window
        run("restart", 37, pb(2, 18), 64'd0, 64'd0, 1'b0);
        check_val("restart_cnt18", h_cnt[18], 1);
        check_val("restart_cnt19", h_cnt[19], 1);
        check_val("restart_warn19", h_warn[19], 1);
        check_val("restart_warn34", h_warn[34], 1);
        check_val("restart_warn35", h_warn[35], 0);

        // Threshold beats window expiry on the same cycle
        run("prio", 21, pb(2, 5, 18), 64'd0, 64'd0, 1'b0);
        check_val("prio_alarm19", h_alarm[19], 1);
        check_val("prio_cnt19", h_cnt[19], THRESH);

        // ACK in IDLE/COUNT has no effect; ACK during hold does not shorten it
        run("ack", 20, pb(2, 5, 8), pb(0, 3, 11), 64'd0, 1'b0);
        check_val("ack_cnt4", h_cnt[4], 1);
        check_val("ack_warn8", h_warn[8], 1);
        check_val("ack_alarm16", h_alarm[16], 1);
        check_val("ack_alarm17", h_alarm[17], 0);

`ifdef CO2_ALARM_LATCH_EN
        // Latched alarm waits for ACK
        run("latch", 33, pb(2, 5, 8), pb(30), 64'd0, 1'b0);
        check_val("latch_alarm17", h_alarm[17], 1);
        check_val("latch_alarm30", h_alarm[30], 1);
        check_val("latch_alarm31", h_alarm[31], 0);
        check_val("latch_cnt31", h_cnt[31], 0);
`endif

        // Randomised traffic against the model
        for (int r = 0; r < 4; r++) begin
            zm = {$urandom, $urandom} & {$urandom, $urandom};
            am = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            if (r == 3) rm = 64'd1 << $urandom_range(20, 59);
            else rm = 64'd0;
            run($sformatf("rand%0d", r), 60, zm, am, rm, 1'($urandom_range(0, 1)));
        end

        check_val("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
